// File: rtl/ahb_dma_pkg.sv
// Shared encodings for the multi-channel AHB DMA descriptor slave:
// bus codes, register map offsets, CTRL bit positions, dispatcher states.
package ahb_dma_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   localparam logic [3:0] OFF_SADDR  = 4'h0;
   localparam logic [3:0] OFF_DADDR  = 4'h4;
   localparam logic [3:0] OFF_NUMBER = 4'h8;
   localparam logic [3:0] OFF_CTRL   = 4'hC;
   localparam logic [8:0] ADDR_IRQ_STAT = 9'h100;

   localparam int CTRL_START = 0;
   localparam int CTRL_IRQEN = 1;
   localparam int CTRL_DONE  = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_BUSY,
      ST_WAIT_DONE
   } dma_st_e;

   // Unaligned, beyond IRQ_STAT, or a channel slot that does not exist.
   function automatic logic addr_bad(input logic [8:0] a, input int nch);
      if (a[1:0] != 2'b00) return 1'b1;
      if (a[8]) return a != ADDR_IRQ_STAT;
      return int'(a[7:4]) >= nch;
   endfunction

endpackage

// File: rtl/dma_rr_arb.sv
// Round-robin pick: first requesting index at or after the pointer,
// wrapping modulo N.
module dma_rr_arb #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_ptr,
   output logic [W-1:0] o_idx,
   output logic         o_valid
);

   // Scan from the far end so the closest request to the pointer wins.
   always_comb begin
      o_idx   = '0;
      o_valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[(int'(i_ptr) + i) % N]) begin
            o_valid = 1'b1;
            o_idx   = W'((int'(i_ptr) + i) % N);
         end
      end
   end

endmodule

// File: rtl/ahb_dma_csr_mc.sv
// AHB-lite descriptor bank for NUM_CH DMA channels with a round-robin
// dispatcher driving one shared engine and a sticky-done level interrupt.
module ahb_dma_csr_mc
   import ahb_dma_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int NUM_W  = 14,
   parameter int ADDR_W = 32
) (
   input  logic              hclk,
   input  logic              hreset,
   input  logic              hsel,
   input  logic              hready_in,
   input  logic              hwrite,
   input  logic [1:0]        htrans,
   input  logic [ADDR_W-1:0] haddr,
   input  logic [31:0]       hwdata,
   output logic [31:0]       hrdata,
   output logic              hready,
   output logic [1:0]        hresp,
   output logic [ADDR_W-1:0] dma_cfg_saddr,
   output logic [ADDR_W-1:0] dma_cfg_daddr,
   output logic [NUM_W-1:0]  dma_cfg_number,
   output logic [2:0]        dma_cfg_ch,
   output logic              dma_axi_start,
   input  logic              dma_axi_done,
   output logic              irq
);

   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [ADDR_W-1:0] r_saddr [NUM_CH];
   logic [ADDR_W-1:0] r_daddr [NUM_CH];
   logic [NUM_W-1:0]  r_num   [NUM_CH];
   logic [NUM_CH-1:0] r_pend, r_busy, r_done, r_irqen;
   logic              r_wr, r_err1, r_err2;
   logic [8:0]        r_waddr;
   logic [CW-1:0]     r_cur, r_rr;
   dma_st_e           r_st, w_st_nxt;

   logic              w_aphase, w_bad, w_wlock, w_wctrl, w_wirq;
   logic              w_pick, w_zero, w_start, w_finish, w_gnt_vld;
   logic [8:0]        w_a;
   logic [CW-1:0]     w_ach, w_wch, w_gnt, w_rr_nxt;
   logic [31:0]       w_rdata;
   logic [NUM_CH-1:0] w_pend_nxt, w_busy_nxt, w_done_set, w_done_clr;
   logic              w_unused;

   assign w_a      = haddr[8:0];
   assign w_unused = ^haddr[ADDR_W-1:9];
   assign w_aphase = hsel & hready_in &
                     (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
   assign w_bad    = addr_bad(w_a, NUM_CH);
   assign w_ach    = w_a[4 +: CW];
   assign w_wch    = r_waddr[4 +: CW];
   assign w_wlock  = r_pend[w_wch] | r_busy[w_wch];
   assign w_wctrl  = r_wr & ~r_waddr[8] & (r_waddr[3:0] == OFF_CTRL);
   assign w_wirq   = r_wr & r_waddr[8];
   assign w_rr_nxt = (r_cur == CW'(NUM_CH - 1)) ? '0 : r_cur + 1'b1;

   assign hready = ~r_err1;
   assign hresp  = (r_err1 | r_err2) ? HRESP_ERROR : HRESP_OKAY;
   assign irq    = |(r_done & r_irqen);

   always_comb begin
      w_rdata = '0;
      if (w_a[8]) begin
         w_rdata = 32'(r_done);
      end else begin
         case (w_a[3:0])
            OFF_SADDR:  w_rdata = 32'(r_saddr[w_ach]);
            OFF_DADDR:  w_rdata = 32'(r_daddr[w_ach]);
            OFF_NUMBER: w_rdata = 32'(r_num[w_ach]);
            OFF_CTRL:   w_rdata = {28'b0, r_done[w_ach], r_busy[w_ach],
                                   r_irqen[w_ach], r_pend[w_ach]};
            default:    w_rdata = '0;
         endcase
      end
   end

   // Reads resolve at the address phase so hrdata is ready with no wait.
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         r_wr    <= 1'b0;
         r_waddr <= '0;
         r_err1  <= 1'b0;
         r_err2  <= 1'b0;
         hrdata  <= '0;
      end else begin
         r_wr   <= w_aphase & hwrite & ~w_bad;
         r_err1 <= w_aphase & w_bad;
         r_err2 <= r_err1;
         if (w_aphase) r_waddr <= w_a;
         if (w_aphase & ~hwrite & ~w_bad) hrdata <= w_rdata;
      end
   end

   dma_rr_arb #(.N(NUM_CH), .W(CW)) u_arb (
      .i_req   (r_pend),
      .i_ptr   (r_rr),
      .o_idx   (w_gnt),
      .o_valid (w_gnt_vld)
   );

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) r_st <= ST_IDLE;
      else        r_st <= w_st_nxt;
   end

   always_comb begin
      w_st_nxt = r_st;
      unique case (r_st)
         ST_IDLE:
            if (w_gnt_vld && dma_axi_done && r_num[w_gnt] != '0)
               w_st_nxt = ST_ISSUE;
         ST_ISSUE:     w_st_nxt = ST_WAIT_BUSY;
         ST_WAIT_BUSY: if (!dma_axi_done) w_st_nxt = ST_WAIT_DONE;
         ST_WAIT_DONE: if (dma_axi_done) w_st_nxt = ST_IDLE;
         default:      w_st_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_pick   = (r_st == ST_IDLE) & w_gnt_vld & dma_axi_done;
      w_zero   = w_pick & (r_num[w_gnt] == '0);
      w_start  = (r_st == ST_ISSUE);
      w_finish = (r_st == ST_WAIT_DONE) & dma_axi_done;
   end

   assign dma_axi_start = w_start;

   // Hardware done-set is applied after the W1C mask so it wins a tie.
   always_comb begin
      w_pend_nxt = r_pend;
      w_busy_nxt = r_busy;
      w_done_set = '0;
      w_done_clr = '0;
      if (w_wctrl) begin
         if (hwdata[CTRL_START] && !w_wlock) w_pend_nxt[w_wch] = 1'b1;
         if (hwdata[CTRL_DONE]) w_done_clr[w_wch] = 1'b1;
      end
      if (w_wirq) w_done_clr = w_done_clr | hwdata[NUM_CH-1:0];
      if (w_zero) begin
         w_pend_nxt[w_gnt] = 1'b0;
         w_done_set[w_gnt] = 1'b1;
      end
      if (w_start) begin
         w_pend_nxt[r_cur] = 1'b0;
         w_busy_nxt[r_cur] = 1'b1;
      end
      if (w_finish) begin
         w_busy_nxt[r_cur] = 1'b0;
         w_done_set[r_cur] = 1'b1;
      end
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         r_saddr        <= '{default: '0};
         r_daddr        <= '{default: '0};
         r_num          <= '{default: '0};
         r_pend         <= '0;
         r_busy         <= '0;
         r_done         <= '0;
         r_irqen        <= '0;
         r_cur          <= '0;
         r_rr           <= '0;
         dma_cfg_saddr  <= '0;
         dma_cfg_daddr  <= '0;
         dma_cfg_number <= '0;
         dma_cfg_ch     <= '0;
      end else begin
         if (r_wr && !r_waddr[8] && !w_wlock) begin
            case (r_waddr[3:0])
               OFF_SADDR:  r_saddr[w_wch] <= ADDR_W'(hwdata);
               OFF_DADDR:  r_daddr[w_wch] <= ADDR_W'(hwdata);
               OFF_NUMBER: r_num[w_wch]   <= hwdata[NUM_W-1:0];
               default:    ;
            endcase
         end
         if (w_wctrl) r_irqen[w_wch] <= hwdata[CTRL_IRQEN];
         if (w_pick) begin
            r_cur          <= w_gnt;
            dma_cfg_saddr  <= r_saddr[w_gnt];
            dma_cfg_daddr  <= r_daddr[w_gnt];
            dma_cfg_number <= r_num[w_gnt];
            dma_cfg_ch     <= 3'(w_gnt);
         end
         if (w_finish) r_rr <= w_rr_nxt;
         r_pend <= w_pend_nxt;
         r_busy <= w_busy_nxt;
         r_done <= (r_done & ~w_done_clr) | w_done_set;
      end
   end

endmodule

// File: tb/tb_ahb_dma_csr_mc.sv
// Scoreboard bench: bus responses and engine start pulses are checked
// against queued expectations by a monitor independent of the driver.
module tb_ahb_dma_csr_mc;

   logic        hclk = 1'b0;
   logic        hreset = 1'b1;
   logic        hsel = 1'b0;
   logic        hwrite = 1'b0;
   logic [1:0]  htrans = 2'b00;
   logic [31:0] haddr = '0;
   logic [31:0] hwdata = '0;
   logic [31:0] hrdata;
   logic        hready;
   logic [1:0]  hresp;
   logic [31:0] cfg_sa, cfg_da;
   logic [13:0] cfg_num;
   logic [2:0]  cfg_ch;
   logic        start;
   logic        done_in = 1'b1;
   logic        irq;

   always #5 hclk = ~hclk;

   ahb_dma_csr_mc dut (
      .hclk           (hclk),
      .hreset         (hreset),
      .hsel           (hsel),
      .hready_in      (hready),
      .hwrite         (hwrite),
      .htrans         (htrans),
      .haddr          (haddr),
      .hwdata         (hwdata),
      .hrdata         (hrdata),
      .hready         (hready),
      .hresp          (hresp),
      .dma_cfg_saddr  (cfg_sa),
      .dma_cfg_daddr  (cfg_da),
      .dma_cfg_number (cfg_num),
      .dma_cfg_ch     (cfg_ch),
      .dma_axi_start  (start),
      .dma_axi_done   (done_in),
      .irq            (irq)
   );

   typedef struct {
      logic        rdy;
      logic [1:0]  resp;
      logic        chk;
      logic [31:0] d;
   } rd_exp_t;

   typedef struct {
      logic [31:0] sa;
      logic [31:0] da;
      logic [13:0] num;
      logic [2:0]  ch;
   } st_exp_t;

   rd_exp_t rd_q[$];
   st_exp_t st_q[$];
   rd_exp_t re;
   st_exp_t se;
   int      n_vec = 0;
   int      n_bad = 0;
   logic    dph = 1'b0;
   int      eng_busy = 6;
   logic    eng_kick = 1'b0;
   logic    got;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   always @(negedge hclk) begin
      if (dph) begin
         if (rd_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL bus_extra: data phase with no expectation");
         end else begin
            re = rd_q.pop_front();
            chk("bus_hready", 32'(hready), 32'(re.rdy));
            chk("bus_hresp", 32'(hresp), 32'(re.resp));
            if (re.chk) chk("bus_hrdata", hrdata, re.d);
         end
      end
      if (start === 1'b1) begin
         if (st_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL start_extra: ch=%0d got pulse, want none", cfg_ch);
         end else begin
            se = st_q.pop_front();
            chk("start_saddr", cfg_sa, se.sa);
            chk("start_daddr", cfg_da, se.da);
            chk("start_number", 32'(cfg_num), 32'(se.num));
            chk("start_ch", 32'(cfg_ch), 32'(se.ch));
         end
      end
   end

   // Behavioural engine: drops done two cycles after start, holds busy.
   always begin
      @(negedge hclk);
      if (start === 1'b1) begin
         repeat (2) @(negedge hclk);
         done_in = 1'b0;
         for (int k = 0; k < eng_busy && !eng_kick; k++) @(negedge hclk);
         done_in = 1'b1;
      end
   end

   task automatic xfer(input logic wr, input logic [31:0] a,
                       input logic [31:0] d);
      @(posedge hclk); #1;
      hsel = 1'b1; hwrite = wr; htrans = 2'b10; haddr = a;
      @(posedge hclk); #1;
      hsel = 1'b0; hwrite = 1'b0; htrans = 2'b00; hwdata = d; dph = 1'b1;
      for (int k = 0; k < 4 && !hready; k++) begin
         @(posedge hclk); #1;
      end
      if (!hready) begin
         n_vec++;
         n_bad++;
         $display("FAIL bus_timeout: hready=%0b, want 1", hready);
      end
      @(posedge hclk); #1;
      dph = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      rd_q.push_back('{1'b1, 2'd0, 1'b0, 32'd0});
      xfer(1'b1, a, d);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp);
      rd_q.push_back('{1'b1, 2'd0, 1'b1, exp});
      xfer(1'b0, a, 32'd0);
   endtask

   task automatic err(input logic w, input logic [31:0] a);
      rd_q.push_back('{1'b0, 2'd1, 1'b0, 32'd0});
      rd_q.push_back('{1'b1, 2'd1, 1'b0, 32'd0});
      xfer(w, a, 32'hFFFF_FFFF);
   endtask

   task automatic exp_start(input logic [31:0] sa, input logic [31:0] da,
                            input logic [13:0] num, input logic [2:0] ch);
      st_q.push_back('{sa, da, num, ch});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge hclk);
      #1;
      chk("rst_hready", 32'(hready), 1);
      chk("rst_hresp", 32'(hresp), 0);
      chk("rst_irq", 32'(irq), 0);
      chk("rst_start", 32'(start), 0);
      chk("rst_hrdata", hrdata, 0);
      chk("rst_cfg_sa", cfg_sa, 0);
      @(negedge hclk);
      hreset = 1'b0;

      // ch0 single transfer, start latency, irq masking
      wr(32'h00, 9);
      wr(32'h04, 16);
      wr(32'h08, 100);
      exp_start(9, 16, 100, 0);
      wr(32'h0C, 1);
      chk("t1_start_early", 32'(start), 0);
      @(posedge hclk); #1;
      chk("t1_start_lat", 32'(start), 1);
      repeat (20) @(posedge hclk);
      chk("t1_cfg_hold_sa", cfg_sa, 9);
      rd(32'h100, 32'h1);
      chk("t1_irq_masked", 32'(irq), 0);
      wr(32'h0C, 32'h2);
      chk("t1_irq_on", 32'(irq), 1);
      rd(32'h0C, 32'hA);
      wr(32'h0C, 32'h8);
      rd(32'h0C, 32'h0);
      chk("t1_irq_off", 32'(irq), 0);

      // three channels back to back, then ch0 after the wrap
      eng_busy = 30;
      wr(32'h10, 32'h100);
      wr(32'h14, 32'h200);
      wr(32'h18, 5);
      wr(32'h20, 32'h300);
      wr(32'h24, 32'h400);
      wr(32'h28, 6);
      wr(32'h30, 32'h500);
      wr(32'h34, 32'h600);
      wr(32'h38, 7);
      exp_start(32'h100, 32'h200, 5, 1);
      wr(32'h1C, 1);
      exp_start(32'h300, 32'h400, 6, 2);
      wr(32'h2C, 1);
      exp_start(32'h500, 32'h600, 7, 3);
      wr(32'h3C, 1);
      exp_start(9, 16, 100, 0);
      wr(32'h0C, 1);

      // writes to a busy / pending channel are dropped
      wr(32'h10, 32'hDEAD);
      wr(32'h1C, 1);
      wr(32'h20, 32'hBEEF);
      rd(32'h10, 32'h100);
      rd(32'h1C, 32'h4);
      chk("t3_cfg_sa", cfg_sa, 32'h100);
      chk("t3_cfg_ch", 32'(cfg_ch), 1);
      repeat (200) @(posedge hclk);

      // error responses and recovery
      err(1'b0, 32'h40);
      rd(32'h100, 32'hF);
      err(1'b1, 32'h02);
      rd(32'h00, 9);
      err(1'b0, 32'h104);
      rd(32'h0C, 32'h8);

      // zero-length descriptor and IRQ_STAT W1C
      wr(32'h100, 32'hF);
      rd(32'h100, 32'h0);
      chk("t5_irq_clr", 32'(irq), 0);
      wr(32'h28, 0);
      wr(32'h2C, 32'h3);
      chk("t5_irq_t1", 32'(irq), 0);
      @(posedge hclk); #1;
      chk("t5_irq_t2", 32'(irq), 1);
      chk("t5_cfg_ch", 32'(cfg_ch), 2);
      chk("t5_cfg_num", 32'(cfg_num), 0);
      chk("t5_cfg_sa", cfg_sa, 32'h300);
      rd(32'h100, 32'h4);
      rd(32'h2C, 32'hA);
      wr(32'h100, 32'h4);
      rd(32'h100, 32'h0);
      chk("t5_irq_w1c", 32'(irq), 0);

      // reset while the engine is mid-transfer
      eng_busy = 1000;
      rd(32'h10, 32'h100);
      exp_start(32'h100, 32'h200, 5, 1);
      wr(32'h1C, 1);
      got = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge hclk);
         if (start === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      chk("t6_start_seen", 32'(got), 1);
      repeat (6) @(negedge hclk);
      hreset = 1'b1;
      #1;
      chk("t6_rst_start", 32'(start), 0);
      chk("t6_rst_sa", cfg_sa, 0);
      chk("t6_rst_da", cfg_da, 0);
      chk("t6_rst_num", 32'(cfg_num), 0);
      chk("t6_rst_ch", 32'(cfg_ch), 0);
      chk("t6_rst_hrdata", hrdata, 0);
      chk("t6_rst_hready", 32'(hready), 1);
      chk("t6_rst_hresp", 32'(hresp), 0);
      @(negedge hclk);
      hreset = 1'b0;
      eng_kick = 1'b1;
      repeat (6) @(posedge hclk);
      rd(32'h1C, 32'h0);
      rd(32'h10, 32'h0);
      rd(32'h100, 32'h0);
      chk("t6_post_sa", cfg_sa, 0);
      chk("t6_post_irq", 32'(irq), 0);

      repeat (5) @(posedge hclk);
      chk("rd_q_empty", rd_q.size(), 0);
      chk("st_q_empty", st_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
